// File: rtl/des_pkg.sv
// Shared types and sizes for the DES message packer.
package des_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        SEND_P1,
        SETUP_P2,
        SEND_P2
    } state_t;

    localparam int BLOCK_W         = 64;
    localparam int HALF_W          = 32;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 8;

endpackage

// File: rtl/des_byte_buffer.sv
// 8-byte block register with write index, pad refill and half views.
module des_byte_buffer
    import des_pkg::*;
#(
    parameter logic [BYTE_W-1:0] PAD_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  logic [BYTE_W-1:0] wr_data,
    output logic [2:0]        idx,
    output logic [HALF_W:1]   part1,
    output logic [HALF_W:1]   part2
);

    logic [BLOCK_W:1] blk_q;
    logic [BLOCK_W:1] blk_d;
    logic [2:0]       idx_d;

    // Halves are taken from the next-state view so the top can register
    // part1 on the same edge that writes the closing byte.
    always_comb begin
        blk_d = blk_q;
        idx_d = idx;
        if (clr) begin
            blk_d = {BYTES_PER_BLOCK{PAD_BYTE}};
            idx_d = '0;
        end else if (wr) begin
            blk_d[BLOCK_W - BYTE_W*int'(idx) -: BYTE_W] = wr_data;
            idx_d = idx + 3'd1;
        end
    end

    assign part1 = blk_d[BLOCK_W:HALF_W+1];
    assign part2 = blk_d[HALF_W:1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_q <= {BYTES_PER_BLOCK{PAD_BYTE}};
            idx   <= '0;
        end else begin
            blk_q <= blk_d;
            idx   <= idx_d;
        end
    end

endmodule

// File: rtl/des_msg_packer.sv
// Byte-stream to DES FSMD half-block feeder.
// Optional handshake watchdog: define DES_PACKER_TIMEOUT_EN.
module des_msg_packer
    import des_pkg::*;
#(
    parameter logic [BYTE_W-1:0] PAD_BYTE    = 8'h00,
    parameter int                TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [HALF_W:1]   msg,
    output logic              ready_part1,
    output logic              ready_part2,
    input  logic              read_part1,
    input  logic              done,
    output logic              busy,
    output logic              err
);

    state_t state_q, state_d;

    logic            accept;
    logic            closing;
    logic            tmo;
    logic            clr;
    logic [2:0]      idx;
    logic [HALF_W:1] part1;
    logic [HALF_W:1] part2;
    logic [HALF_W:1] msg_d;
    logic            rp1_d;
    logic            rp2_d;
    logic            busy_d;
    logic            err_d;

    assign in_ready = (state_q == COLLECT);
    assign accept   = in_valid & in_ready;
    assign closing  = accept &
                      (in_last | (idx == 3'(BYTES_PER_BLOCK-1)));
    assign clr      = ((state_q == SEND_P2) & done) | tmo;

    des_byte_buffer #(
        .PAD_BYTE (PAD_BYTE)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr      (accept),
        .wr_data (in_data),
        .idx     (idx),
        .part1   (part1),
        .part2   (part2)
    );

`ifdef DES_PACKER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state_q == COLLECT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tmo = (state_q != COLLECT) &&
                 (cnt == CNT_W'(TIMEOUT_CYC - 1)) &&
                 !((state_q == SEND_P1) && read_part1) &&
                 !((state_q == SEND_P2) && done);
`else
    // No watchdog: the handshake waits indefinitely.
    assign tmo = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    always_comb begin
        state_d = state_q;
        msg_d   = msg;
        rp1_d   = ready_part1;
        rp2_d   = ready_part2;
        busy_d  = busy;
        err_d   = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (closing) begin
                    state_d = SEND_P1;
                    msg_d   = part1;
                    rp1_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SEND_P1: begin
                if (read_part1) begin
                    state_d = SETUP_P2;
                    msg_d   = part2;
                    rp1_d   = 1'b0;
                end
            end
            // msg already carries part2 here, so the FSMD samples it
            // at least once before ready_part2 rises.
            SETUP_P2: begin
                state_d = SEND_P2;
                rp2_d   = 1'b1;
            end
            SEND_P2: begin
                if (done) begin
                    state_d = COLLECT;
                    msg_d   = '0;
                    rp2_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase
        if (tmo) begin
            state_d = COLLECT;
            msg_d   = '0;
            rp1_d   = 1'b0;
            rp2_d   = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= COLLECT;
            msg         <= '0;
            ready_part1 <= 1'b0;
            ready_part2 <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            msg         <= msg_d;
            ready_part1 <= rp1_d;
            ready_part2 <= rp2_d;
            busy        <= busy_d;
            err         <= err_d;
        end
    end

endmodule
